alu_sequencer: RTL

Multi-cycle control unit that drives the combinational ALU from the initiator side. It fetches 32-bit instruction words, reads operands from an internal 8×32 register file, and presents operands and opcode to the ALU. It captures the ALU result and C/S/O/Z flags, services load/store through a data-memory handshake, and resolves jumps on the captured flags. It sits between instruction/data memory and the ALU, and owns the architectural PC, registers and flag register.

---
 rtl/alu_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit: fetches instructions, sequences the external ALU,
// services load/store through a data-memory handshake and resolves jumps on flags.
module alu_sequencer #(
    parameter int BITS_DATA = 32,
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [ADDR_BITS-1:0] imem_addr,
    input  logic [31:0]          imem_data,
    input  logic                 imem_valid,
    output logic                 dmem_re,
    output logic                 dmem_we,
    output logic [ADDR_BITS-1:0] dmem_addr,
    output logic [BITS_DATA-1:0] dmem_wdata,
    input  logic [BITS_DATA-1:0] dmem_rdata,
    input  logic                 dmem_ack,
    output logic [BITS_DATA-1:0] alu_a,
    output logic [BITS_DATA-1:0] alu_b,
    output logic [4:0]           alu_opcode,
    input  logic [BITS_DATA-1:0] alu_result,
    input  logic                 alu_c,
    input  logic                 alu_s,
    input  logic                 alu_o,
    input  logic                 alu_z,
    output logic [3:0]           flags,
    output logic [ADDR_BITS-1:0] pc,
    output logic                 halted
);

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_MUL = 5'd3;
    localparam logic [4:0] OP_AND = 5'd6;
    localparam logic [4:0] OP_OR  = 5'd7;
    localparam logic [4:0] OP_NOT = 5'd9;
    localparam logic [4:0] OP_NEG = 5'd10;
    localparam logic [4:0] OP_LD  = 5'd16;
    localparam logic [4:0] OP_STR = 5'd17;
    localparam logic [4:0] OP_JMP = 5'd18;
    localparam logic [4:0] OP_JC  = 5'd19;
    localparam logic [4:0] OP_JS  = 5'd20;
    localparam logic [4:0] OP_JO  = 5'd21;
    localparam logic [4:0] OP_JZ  = 5'd22;
    localparam logic [4:0] OP_HLT = 5'd31;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t               state_q;
    logic [4:0]           op_q;
    logic [2:0]           rd_q, ra_q, rb_q;
    logic [15:0]          imm_q;
    logic [ADDR_BITS-1:0] pc_q, pc_d;
    logic [3:0]           flags_q;
    logic [3:0]           res_flags_q;
    logic [BITS_DATA-1:0] res_q;
    logic [BITS_DATA-1:0] regs_q [0:7];
    logic                 imem_req_q;
    logic                 dmem_re_q, dmem_we_q;
    logic [ADDR_BITS-1:0] dmem_addr_q;
    logic [BITS_DATA-1:0] dmem_wdata_q;
    logic [BITS_DATA-1:0] alu_a_q, alu_b_q;
    logic [4:0]           alu_op_q;
    logic                 halted_q;
    logic                 unused_ir;

    assign unused_ir = ^imem_data[17:16];

    function automatic logic is_alu_op(input logic [4:0] op);
        return op inside {OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB, OP_MUL};
    endfunction

    // Branch resolution uses the architectural flags, already updated by the prior instruction.
    always_comb begin
        pc_d = pc_q + ADDR_BITS'(1);
        case (op_q)
            OP_JMP: pc_d = ADDR_BITS'(imm_q);
            OP_JC:  if (flags_q[3]) pc_d = ADDR_BITS'(imm_q);
            OP_JS:  if (flags_q[2]) pc_d = ADDR_BITS'(imm_q);
            OP_JO:  if (flags_q[1]) pc_d = ADDR_BITS'(imm_q);
            OP_JZ:  if (flags_q[0]) pc_d = ADDR_BITS'(imm_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            op_q         <= OP_NOP;
            rd_q         <= '0;
            ra_q         <= '0;
            rb_q         <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            flags_q      <= '0;
            res_flags_q  <= '0;
            res_q        <= '0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            imem_req_q   <= 1'b0;
            dmem_re_q    <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= OP_NOP;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // Coming out of reset the request is not yet raised; a strobe then is stale.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_valid) begin
                        op_q       <= imem_data[31:27];
                        rd_q       <= imem_data[26:24];
                        ra_q       <= imem_data[23:21];
                        rb_q       <= imem_data[20:18];
                        imm_q      <= imem_data[15:0];
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_a_q  <= regs_q[ra_q];
                    alu_b_q  <= regs_q[rb_q];
                    alu_op_q <= is_alu_op(op_q) ? op_q : OP_NOP;
                    state_q  <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    alu_op_q    <= OP_NOP;
                    res_q       <= alu_result;
                    res_flags_q <= {alu_c & (op_q != OP_MUL), alu_s, alu_o, alu_z};
                    case (op_q)
                        OP_LD: begin
                            dmem_re_q   <= 1'b1;
                            dmem_addr_q <= ADDR_BITS'(imm_q);
                            state_q     <= S_MEM;
                        end
                        OP_STR: begin
                            dmem_we_q    <= 1'b1;
                            dmem_addr_q  <= ADDR_BITS'(imm_q);
                            dmem_wdata_q <= regs_q[ra_q];
                            state_q      <= S_MEM;
                        end
                        OP_HLT: begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                        default: state_q <= S_WRITEBACK;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (dmem_re_q) res_q <= dmem_rdata;
                        dmem_re_q <= 1'b0;
                        dmem_we_q <= 1'b0;
                        state_q   <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    if (is_alu_op(op_q)) begin
                        regs_q[rd_q] <= res_q;
                        flags_q      <= res_flags_q;
                    end else if (op_q == OP_LD) begin
                        regs_q[rd_q] <= res_q;
                    end
                    pc_q       <= pc_d;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_re    = dmem_re_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign flags      = flags_q;
    assign pc         = pc_q;
    assign halted     = halted_q;

endmodule
